posit_encode_sum_es3: RTL and testbench
=======================================

Name: posit_encode_sum_es3

Overview:
- Pipelined encoder that packs a raw serialized ES3 sum into a 32-bit posit word (es=3). Input fields are sgn, scale, fraction, inf and zero.
- It is the other end of the adder's raw-sum output. Its input format is exactly the adder's result and truncated outputs.
- It performs regime/exponent construction, round-to-nearest-even (RNE) with sticky, saturation and two's-complement negation.
- It is the output stage of the ES3 accumulate path, feeding memory writeback.

Parameters:
- N, 32, posit word width.
- ES, 3, exponent field width.
- FBITS, 30, raw fraction width (hidden bit excluded, MSB-first).
- SW, 9, signed scale width.
- MAXSCALE, (N-2)*2^ES = 240, largest representable scale magnitude.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, input valid; one operand per asserted cycle.
- in, input, 42, raw sum. Bit layout: [41] sgn, [40:32] scale (signed), [31:2] fraction, [1] inf, [0] zero.
- truncated_in, input, 1, bits were lost upstream; ORed into the sticky bit.
- result, output, 32, encoded posit.
- done, output, 1, result valid.
- inexact, output, 1, result differs from the exact input (guard|sticky, or saturation applied).

Behaviour:
- Reset and handshake:
  - One clock domain; reset is asynchronous and active-high.
  - rst clears all stage-valid bits and forces result=0, done=0, inexact=0. Reset mid-operation discards all in-flight operands; no done pulse follows for them.
  - Fully pipelined with no backpressure: accepts one operand per cycle.
  - Latency is exactly 3 cycles: start sampled at edge t gives done high after edge t+3, for one cycle per operand. Back-to-back starts give back-to-back dones in order.
  - start that is X is treated as 0.
- Stage 1 (register input):
  - Classify with priority inf > zero > overflow > underflow > normal.
  - Split scale into k = scale >>> 3 (arithmetic shift) and e = scale[2:0].
- Stage 2 (build magnitude):
  - Regime: if k>=0, (k+1) ones then one zero; if k<0, (-k) zeros then one one.
  - Form the bit string {regime, e, fraction} after a leading 0 sign bit.
  - Right-shift so the regime starts at bit N-2.
  - Keep 31 magnitude bits. guard = first dropped bit. sticky = OR of the remaining dropped bits | truncated_in.
- Stage 3 (round and pack):
  - RNE: increment if guard & (lsb | sticky).
  - If the increment carries to 0x80000000, clamp to 0x7FFFFFFF.
  - A nonzero magnitude never rounds to 0; a rounded magnitude of 0 becomes 0x00000001.
  - If sgn=1, result = two's complement of {0, magnitude}.
- Special cases:
  - scale > 240: magnitude 0x7FFFFFFF, inexact=1.
  - scale < -240: magnitude 0x00000001, inexact=1.
  - inf=1: result 0x80000000, inexact=0, regardless of the other fields.
  - zero=1 (and inf=0): result 0x00000000, inexact=0, sgn ignored.
- Outputs hold their last value while done=0.

Test Plan:
- 1.0 and -1.0: in{sgn=0,scale=0,frac=0} -> 0x40000000; sgn=1 -> 0xC0000000; done exactly 3 cycles after start, inexact=0.
- Regime and exponent:
  - scale=8 -> 0x60000000.
  - scale=-1 -> 0x3C000000.
  - scale=-240 -> 0x00000001.
  - scale=240 -> 0x7FFFFFFF.
- RNE tie: scale=0, fraction bit[3] only set.
  - truncated_in=0 -> 0x40000000, inexact=1.
  - truncated_in=1 -> 0x40000001.
  - fraction bits[4] and [3] set -> 0x40000002.
- Saturation:
  - scale=250 -> 0x7FFFFFFF.
  - scale=-250, sgn=1 -> 0xFFFFFFFF.
  - Both with inexact=1.
- Specials:
  - inf=1, zero=1 -> 0x80000000.
  - zero=1, sgn=1 -> 0x00000000.
- Pipeline:
  - 5 back-to-back starts -> 5 consecutive done cycles, results in order.
  - rst asserted one cycle after 2 starts -> no done pulses; outputs all 0 immediately on rst.

Source files
------------

// File: rtl/posit_encode_sum_es3.sv
`default_nettype none
// ============================================================================
//  Module   : posit_encode_sum_es3
//  Purpose  : Pipelined encoder that packs a raw ES3 sum (sign, scale,
//             fraction, inf, zero) into a 32-bit posit word. It builds the
//             regime and exponent, rounds to nearest even with sticky,
//             saturates, and negates the word for negative values.
//  Ports    : clk          - rising-edge clock
//             rst          - asynchronous active-high reset
//             start        - operand valid, one operand per cycle
//             in[41:0]     - raw sum {sgn, scale[8:0], frac[29:0], inf, zero}
//             truncated_in - upstream lost bits (joins the sticky bit)
//             result[31:0] - encoded posit (holds while done is low)
//             done         - result valid, 3 cycles after start
//             inexact      - result differs from the exact input
//  Revision : 1.0 - initial release
// ============================================================================
module posit_encode_sum_es3 #(
  parameter int N        = 32,
  parameter int ES       = 3,
  parameter int FBITS    = 30,
  parameter int SW       = 9,
  parameter int MAXSCALE = (N - 2) * (2 ** ES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1+SW+FBITS+2-1:0]     in,
  input  logic                        truncated_in,
  output logic [N-1:0]                result,
  output logic                        done,
  output logic                        inexact
);

  localparam int IW  = 1 + SW + FBITS + 2;
  // Working string: room for the longest regime run plus the terminator,
  // exponent and fraction, so nothing meaningful falls off the bottom.
  localparam int M   = (N - 1) + 1 + ES + FBITS + 1;
  localparam int PAD = M - (1 + ES + FBITS);

  localparam logic signed [SW:0] MAXS = (SW+1)'(MAXSCALE);
  localparam logic signed [SW:0] MINS = -MAXS;

  localparam logic [2:0] C_NORM = 3'd0;
  localparam logic [2:0] C_INF  = 3'd1;
  localparam logic [2:0] C_ZERO = 3'd2;
  localparam logic [2:0] C_OVF  = 3'd3;
  localparam logic [2:0] C_UNF  = 3'd4;

  // ---------------------------------------------------------------- stage 0
  logic          v0;
  logic [IW-1:0] in_q;
  logic          trunc0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0     <= 1'b0;
      in_q   <= '0;
      trunc0 <= 1'b0;
    end else begin
      // Case equality so an unknown start never launches an operand.
      v0     <= (start === 1'b1);
      in_q   <= in;
      trunc0 <= truncated_in;
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic signed [SW-1:0] scale_w;
  logic signed [SW:0]   scale_ext;
  logic signed [SW-1:0] k_w;
  logic [2:0]           cls_w;

  assign scale_w   = in_q[IW-2 -: SW];
  assign scale_ext = {scale_w[SW-1], scale_w};
  assign k_w       = scale_w >>> ES;

  always_comb begin
    cls_w = C_NORM;
    if (in_q[1])               cls_w = C_INF;
    else if (in_q[0])          cls_w = C_ZERO;
    else if (scale_ext > MAXS) cls_w = C_OVF;
    else if (scale_ext < MINS) cls_w = C_UNF;
  end

  logic             v1, sgn1, trunc1;
  logic [2:0]       cls1;
  logic [SW-1:0]    k1;
  logic [ES-1:0]    e1;
  logic [FBITS-1:0] frac1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      sgn1   <= 1'b0;
      trunc1 <= 1'b0;
      cls1   <= C_NORM;
      k1     <= '0;
      e1     <= '0;
      frac1  <= '0;
    end else begin
      v1     <= v0;
      sgn1   <= in_q[IW-1];
      trunc1 <= trunc0;
      cls1   <= cls_w;
      k1     <= k_w;
      e1     <= scale_w[ES-1:0];
      frac1  <= in_q[FBITS+1:2];
    end
  end

  // ---------------------------------------------------------------- stage 2
  // The regime is a run of fill bits followed by an opposite terminator.
  // The terminator, exponent and fraction are placed at the top of the
  // string and shifted right by the run length while the vacated top bits
  // are filled with the run value.
  logic          fill_w;
  logic [SW-1:0] run_w;
  logic [M-1:0]  base_w;
  logic [M-1:0]  shifted_w;

  always_comb begin
    fill_w    = ~k1[SW-1];
    run_w     = k1[SW-1] ? (~k1 + SW'(1)) : (k1 + SW'(1));
    base_w    = {k1[SW-1], e1, frac1, {PAD{1'b0}}};
    shifted_w = (base_w >> run_w) | (fill_w ? ~({M{1'b1}} >> run_w) : '0);
  end

  logic         v2, sgn2, guard2, sticky2;
  logic [2:0]   cls2;
  logic [N-2:0] mag2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2      <= 1'b0;
      sgn2    <= 1'b0;
      guard2  <= 1'b0;
      sticky2 <= 1'b0;
      cls2    <= C_NORM;
      mag2    <= '0;
    end else begin
      v2      <= v1;
      sgn2    <= sgn1;
      cls2    <= cls1;
      mag2    <= shifted_w[M-1 -: N-1];
      guard2  <= shifted_w[M-N];
      sticky2 <= (|shifted_w[M-N-1:0]) | trunc1;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic         rnd_up;
  logic [N-1:0] sum_w;
  logic [N-2:0] mag_f;
  logic [N-1:0] pos_w;
  logic         inx_w;

  always_comb begin
    rnd_up = guard2 & (mag2[0] | sticky2);
    sum_w  = {1'b0, mag2} + {{(N-1){1'b0}}, rnd_up};
    mag_f  = sum_w[N-2:0];
    inx_w  = guard2 | sticky2;
    // Rounding past maxpos saturates; a nonzero value never collapses to 0.
    if (sum_w[N-1])       mag_f = {(N-1){1'b1}};
    else if (sum_w == '0) mag_f = {{(N-2){1'b0}}, 1'b1};
    case (cls2)
      C_OVF: begin
        mag_f = {(N-1){1'b1}};
        inx_w = 1'b1;
      end
      C_UNF: begin
        mag_f = {{(N-2){1'b0}}, 1'b1};
        inx_w = 1'b1;
      end
      default: ;
    endcase
    pos_w = sgn2 ? (~{1'b0, mag_f} + N'(1)) : {1'b0, mag_f};
    if (cls2 == C_INF) begin
      pos_w = {1'b1, {(N-1){1'b0}}};
      inx_w = 1'b0;
    end else if (cls2 == C_ZERO) begin
      pos_w = '0;
      inx_w = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      result  <= '0;
      inexact <= 1'b0;
    end else begin
      done <= v2;
      if (v2) begin
        result  <= pos_w;
        inexact <= inx_w;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_posit_encode_sum_es3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_posit_encode_sum_es3
//  Purpose  : Self-checking bench for posit_encode_sum_es3. A table of
//             directed vectors with hand-computed posit words is applied one
//             at a time, followed by back-to-back and mid-flight reset runs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_posit_encode_sum_es3;

  logic        clk;
  logic        rst;
  logic        start;
  logic [41:0] in_bus;
  logic        truncated_in;
  logic [31:0] result;
  logic        done;
  logic        inexact;

  int n_checks;
  int n_fail;

  posit_encode_sum_es3 dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in           (in_bus),
    .truncated_in (truncated_in),
    .result       (result),
    .done         (done),
    .inexact      (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic              sgn;
    logic signed [8:0] scale;
    logic [29:0]       frac;
    logic              inf;
    logic              zero;
    logic              trunc;
    logic [31:0]       exp_res;
    logic              exp_inx;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input string nm, input logic s, input int sc,
                              input logic [29:0] f, input logic fi, input logic fz,
                              input logic tr, input logic [31:0] er, input logic ei);
    vec_t v;
    v.name = nm; v.sgn = s; v.scale = 9'(sc); v.frac = f; v.inf = fi;
    v.zero = fz; v.trunc = tr; v.exp_res = er; v.exp_inx = ei;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_bus       = {v.sgn, v.scale, v.frac, v.inf, v.zero};
    truncated_in = v.trunc;
    start        = 1'b1;
  endtask

  // One isolated operand: latency, value and inexact flag.
  task automatic run_one(input vec_t v);
    int lat;
    @(negedge clk);
    drive(v);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({v.name, " latency"}, 32'(lat), 32'd3);
    check({v.name, " result"}, result, v.exp_res);
    check({v.name, " inexact"}, {31'd0, inexact}, {31'd0, v.exp_inx});
  endtask

  initial begin
    int got;
    int ndone;
    logic [31:0] b2b_exp[5];
    int          b2b_idx[5];

    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    in_bus       = '0;
    truncated_in = 1'b0;

    //            name        sgn scale  frac                      inf zero tr  expected      inx
    tv.push_back(mk("one",      0,    0, 30'd0,                    0, 0,   0, 32'h40000000, 0));
    tv.push_back(mk("minus1",   1,    0, 30'd0,                    0, 0,   0, 32'hC0000000, 0));
    tv.push_back(mk("sc8",      0,    8, 30'd0,                    0, 0,   0, 32'h60000000, 0));
    tv.push_back(mk("scm1",     0,   -1, 30'd0,                    0, 0,   0, 32'h3C000000, 0));
    tv.push_back(mk("scm240",   0, -240, 30'd0,                    0, 0,   0, 32'h00000001, 0));
    tv.push_back(mk("sc240",    0,  240, 30'd0,                    0, 0,   0, 32'h7FFFFFFF, 0));
    tv.push_back(mk("tie",      0,    0, 30'h8,                    0, 0,   0, 32'h40000000, 1));
    tv.push_back(mk("tie_trc",  0,    0, 30'h8,                    0, 0,   1, 32'h40000001, 1));
    tv.push_back(mk("tie_odd",  0,    0, 30'h18,                   0, 0,   0, 32'h40000002, 1));
    tv.push_back(mk("neg_odd",  1,    0, 30'h18,                   0, 0,   0, 32'hBFFFFFFE, 1));
    tv.push_back(mk("sat_hi",   0,  250, 30'd0,                    0, 0,   0, 32'h7FFFFFFF, 1));
    tv.push_back(mk("sat_lo_n", 1, -250, 30'd0,                    0, 0,   0, 32'hFFFFFFFF, 1));
    tv.push_back(mk("sat_lo_p", 0, -250, 30'd0,                    0, 0,   0, 32'h00000001, 1));
    tv.push_back(mk("inf",      1,    5, 30'h155,                  1, 1,   1, 32'h80000000, 0));
    tv.push_back(mk("zero_neg", 1,   17, 30'h3FF,                  0, 1,   1, 32'h00000000, 0));
    tv.push_back(mk("fr_ones",  0,    0, 30'h3FFFFFFF,             0, 0,   0, 32'h44000000, 1));
    tv.push_back(mk("sc239",    0,  239, 30'd0,                    0, 0,   0, 32'h7FFFFFFF, 1));
    tv.push_back(mk("sc17",     0,   17, 30'd0,                    0, 0,   0, 32'h71000000, 0));
    tv.push_back(mk("scm9",     0,   -9, 30'd0,                    0, 0,   0, 32'h1E000000, 0));

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst inexact", {31'd0, inexact}, 32'd0);
    rst = 1'b0;

    foreach (tv[i]) run_one(tv[i]);

    // Back-to-back: five consecutive starts give five consecutive dones.
    b2b_idx = '{0, 2, 3, 7, 10};
    foreach (b2b_idx[i]) b2b_exp[i] = tv[b2b_idx[i]].exp_res;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) begin
        if (got < 5) begin
          check("b2b result", result, b2b_exp[got]);
          check("b2b cycle", 32'(c), 32'(got + 4));
        end else begin
          check("b2b extra done", 32'(got), 32'd4);
        end
        got++;
      end
      if (c < 5) drive(tv[b2b_idx[c]]);
      else       start = 1'b0;
    end
    check("b2b count", 32'(got), 32'd5);

    // Reset one cycle after two starts: outputs clear at once, no dones follow.
    @(negedge clk);
    drive(tv[1]);
    @(negedge clk);
    drive(tv[2]);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    #1;
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst inexact", {31'd0, inexact}, 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst dones", 32'(ndone), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
